fir_stream_driver: RTL and testbench

// Transmit-side sequencer for fir_convolution's load interface. It takes coefficients and samples

---
 rtl/fir_pkg.sv | 19 +
 rtl/fir_coef_bank.sv | 28 ++
 rtl/fir_stream_driver.sv | 193 +++++++++++++++++++
 tb/tb_fir_stream_driver.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR load-side sequencer and its filter core.
// FILL collects taps, START/BURST stream them, DATA streams samples, STOP_WAIT drains.
package fir_pkg;

  typedef enum logic [2:0] {
    FILL      = 3'd0,
    START     = 3'd1,
    BURST     = 3'd2,
    DATA      = 3'd3,
    STOP_WAIT = 3'd4
  } fir_state_e;

  localparam int STOP_WAIT_CYCLES = 3;

  localparam int FIR_LENGTH     = 20;
  localparam int FIR_DATA_WIDTH = 18;
  localparam int FIR_CNT_WIDTH  = 16;

endpackage

// File: rtl/fir_coef_bank.sv
// Coefficient register file: one write port filled from upstream, one indexed read port
// feeding the coefficient burst.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int LENGTH     = FIR_LENGTH,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int IDX_W      = $clog2(LENGTH)
) (
  input  logic                  clock,
  input  logic                  wr_en_i,
  input  logic [IDX_W-1:0]      wr_idx_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [IDX_W-1:0]      rd_idx_i,
  output logic [DATA_WIDTH-1:0] rd_data_o
);

  logic [DATA_WIDTH-1:0] bank_q [LENGTH];

  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      bank_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = bank_q[rd_idx_i];

endmodule

// File: rtl/fir_stream_driver.sv
// Transmit-side sequencer for the FIR core load interface: collects a coefficient set,
// bursts it gap-free, then forwards one frame of samples with a stop flag on the last.
module fir_stream_driver
  import fir_pkg::*;
#(
  parameter int LENGTH     = FIR_LENGTH,
  parameter int DATA_WIDTH = FIR_DATA_WIDTH,
  parameter int CNT_WIDTH  = FIR_CNT_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] coef_in_data,
  input  logic                  coef_in_valid,
  output logic                  coef_in_ready,
  input  logic [DATA_WIDTH-1:0] samp_in_data,
  input  logic                  samp_in_valid,
  input  logic                  samp_in_last,
  output logic                  samp_in_ready,
  output logic                  load_coeff_flag,
  output logic                  coeff_set_flag,
  output logic [DATA_WIDTH-1:0] coeff_in,
  output logic                  load_data_flag,
  output logic                  stop_data_load_flag,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  busy,
  output logic                  frame_done,
  output logic [CNT_WIDTH-1:0]  sample_count
);

  localparam int IDX_W = $clog2(LENGTH);
  localparam int SW_W  = $clog2(STOP_WAIT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LENGTH - 1);
  localparam logic [SW_W-1:0]  SW_LOAD  = SW_W'(STOP_WAIT_CYCLES - 1);

  fir_state_e            state_q, state_d;
  logic [IDX_W-1:0]      fill_cnt_q, fill_cnt_d;
  logic [IDX_W-1:0]      burst_cnt_q, burst_cnt_d;
  logic [SW_W-1:0]       stop_cnt_q, stop_cnt_d;
  logic                  first_q, first_d;
  logic [CNT_WIDTH-1:0]  sample_count_q, sample_count_d;
  logic [DATA_WIDTH-1:0] data_in_q, data_in_d;
  logic [DATA_WIDTH-1:0] coeff_in_q, coeff_in_d;
  logic                  load_data_flag_q, load_data_flag_d;
  logic                  stop_flag_q, stop_flag_d;
  logic                  coef_in_ready_q, coef_in_ready_d;
  logic                  samp_in_ready_q, samp_in_ready_d;
  logic                  load_coeff_flag_q, load_coeff_flag_d;
  logic                  coeff_set_flag_q, coeff_set_flag_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  bank_we;
  logic [DATA_WIDTH-1:0] bank_rd;

  fir_coef_bank #(
    .LENGTH     (LENGTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_coef_bank (
    .clock     (clock),
    .wr_en_i   (bank_we),
    .wr_idx_i  (fill_cnt_q),
    .wr_data_i (coef_in_data),
    .rd_idx_i  (burst_cnt_d),
    .rd_data_o (bank_rd)
  );

  always_comb begin
    state_d          = state_q;
    fill_cnt_d       = fill_cnt_q;
    burst_cnt_d      = burst_cnt_q;
    stop_cnt_d       = stop_cnt_q;
    first_d          = first_q;
    sample_count_d   = sample_count_q;
    data_in_d        = data_in_q;
    load_data_flag_d = 1'b0;
    stop_flag_d      = 1'b0;
    bank_we          = 1'b0;

    unique case (state_q)
      FILL: begin
        if (coef_in_ready_q && coef_in_valid) begin
          bank_we = 1'b1;
          if (fill_cnt_q == LAST_IDX) begin
            state_d    = START;
            fill_cnt_d = '0;
          end else begin
            fill_cnt_d = fill_cnt_q + 1'b1;
          end
        end
      end
      START: begin
        state_d     = BURST;
        burst_cnt_d = '0;
        first_d     = 1'b1;
      end
      BURST: begin
        if (burst_cnt_q == LAST_IDX) begin
          state_d = DATA;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (samp_in_ready_q && samp_in_valid) begin
          load_data_flag_d = 1'b1;
          data_in_d        = samp_in_data;
          stop_flag_d      = samp_in_last;
          first_d          = 1'b0;
          // The count restarts with the first sample so it holds across the idle gap.
          if (first_q) begin
            sample_count_d = CNT_WIDTH'(1);
          end else if (sample_count_q != {CNT_WIDTH{1'b1}}) begin
            sample_count_d = sample_count_q + 1'b1;
          end
          if (samp_in_last) begin
            state_d    = STOP_WAIT;
            stop_cnt_d = SW_LOAD;
          end
        end
      end
      STOP_WAIT: begin
        if (stop_cnt_q == '0) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end else begin
          stop_cnt_d = stop_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase

    coef_in_ready_d   = (state_d == FILL);
    samp_in_ready_d   = (state_d == DATA);
    load_coeff_flag_d = (state_d == START);
    coeff_set_flag_d  = (state_q == BURST) && (state_d == DATA);
    coeff_in_d        = (state_d == BURST) ? bank_rd : '0;
    busy_d            = (state_d != FILL);
    frame_done_d      = (state_d == STOP_WAIT) && (stop_cnt_d == '0);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q           <= FILL;
      fill_cnt_q        <= '0;
      burst_cnt_q       <= '0;
      stop_cnt_q        <= '0;
      first_q           <= 1'b0;
      sample_count_q    <= '0;
      data_in_q         <= '0;
      coeff_in_q        <= '0;
      load_data_flag_q  <= 1'b0;
      stop_flag_q       <= 1'b0;
      coef_in_ready_q   <= 1'b1;
      samp_in_ready_q   <= 1'b0;
      load_coeff_flag_q <= 1'b0;
      coeff_set_flag_q  <= 1'b0;
      busy_q            <= 1'b0;
      frame_done_q      <= 1'b0;
    end else begin
      state_q           <= state_d;
      fill_cnt_q        <= fill_cnt_d;
      burst_cnt_q       <= burst_cnt_d;
      stop_cnt_q        <= stop_cnt_d;
      first_q           <= first_d;
      sample_count_q    <= sample_count_d;
      data_in_q         <= data_in_d;
      coeff_in_q        <= coeff_in_d;
      load_data_flag_q  <= load_data_flag_d;
      stop_flag_q       <= stop_flag_d;
      coef_in_ready_q   <= coef_in_ready_d;
      samp_in_ready_q   <= samp_in_ready_d;
      load_coeff_flag_q <= load_coeff_flag_d;
      coeff_set_flag_q  <= coeff_set_flag_d;
      busy_q            <= busy_d;
      frame_done_q      <= frame_done_d;
    end
  end

  assign coef_in_ready       = coef_in_ready_q;
  assign samp_in_ready       = samp_in_ready_q;
  assign load_coeff_flag     = load_coeff_flag_q;
  assign coeff_set_flag      = coeff_set_flag_q;
  assign coeff_in            = coeff_in_q;
  assign load_data_flag      = load_data_flag_q;
  assign stop_data_load_flag = stop_flag_q;
  assign data_in             = data_in_q;
  assign busy                = busy_q;
  assign frame_done          = frame_done_q;
  assign sample_count        = sample_count_q;

endmodule

// File: tb/tb_fir_stream_driver.sv
// Bench for fir_stream_driver: each frame is planned as a per-cycle expected trace built from
// event timing (last coef handshake, sample handshakes), then driven and compared every cycle.
module tb_fir_stream_driver;

  localparam int L    = 4;
  localparam int DW   = 18;
  localparam int CW   = 4;
  localparam int MAXC = 4096;
  localparam int CMAX = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] coef_in_data = '0;
  logic          coef_in_valid = 1'b0;
  logic          coef_in_ready;
  logic [DW-1:0] samp_in_data = '0;
  logic          samp_in_valid = 1'b0;
  logic          samp_in_last = 1'b0;
  logic          samp_in_ready;
  logic          load_coeff_flag;
  logic          coeff_set_flag;
  logic [DW-1:0] coeff_in;
  logic          load_data_flag;
  logic          stop_data_load_flag;
  logic [DW-1:0] data_in;
  logic          busy;
  logic          frame_done;
  logic [CW-1:0] sample_count;

  fir_stream_driver #(.LENGTH(L), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .coef_in_data        (coef_in_data),
    .coef_in_valid       (coef_in_valid),
    .coef_in_ready       (coef_in_ready),
    .samp_in_data        (samp_in_data),
    .samp_in_valid       (samp_in_valid),
    .samp_in_last        (samp_in_last),
    .samp_in_ready       (samp_in_ready),
    .load_coeff_flag     (load_coeff_flag),
    .coeff_set_flag      (coeff_set_flag),
    .coeff_in            (coeff_in),
    .load_data_flag      (load_data_flag),
    .stop_data_load_flag (stop_data_load_flag),
    .data_in             (data_in),
    .busy                (busy),
    .frame_done          (frame_done),
    .sample_count        (sample_count)
  );

  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;
  int t_cur   = 0;
  int t_now   = 0;
  int cyc     = 0;
  int stop_t  = 0;
  int lcf_t   = 0;

  logic [DW-1:0] m_data;
  logic [CW-1:0] m_cnt;
  logic [DW-1:0] samp_q [$];

  logic          e_cr [MAXC];
  logic          e_sr [MAXC];
  logic          e_lcf [MAXC];
  logic          e_csf [MAXC];
  logic          e_ldf [MAXC];
  logic          e_stop [MAXC];
  logic          e_busy [MAXC];
  logic          e_fd [MAXC];
  logic [DW-1:0] e_coeff [MAXC];
  logic [DW-1:0] e_data [MAXC];
  logic [CW-1:0] e_cnt [MAXC];
  logic          i_cv [MAXC];
  logic [DW-1:0] i_cd [MAXC];
  logic          i_sv [MAXC];
  logic [DW-1:0] i_sd [MAXC];
  logic          i_sl [MAXC];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (stop_data_load_flag) stop_t <= cyc;
    if (load_coeff_flag) lcf_t <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", tag, t_cur, obs, exp);
    end
  endtask

  function automatic void base(input int t, input bit is_busy);
    e_cr[t] = !is_busy;  e_busy[t] = is_busy;
    e_sr[t] = 1'b0;      e_lcf[t] = 1'b0;  e_csf[t] = 1'b0;
    e_ldf[t] = 1'b0;     e_stop[t] = 1'b0; e_fd[t] = 1'b0;
    e_coeff[t] = '0;     e_data[t] = m_data; e_cnt[t] = m_cnt;
  endfunction

  function automatic void junk(input int t);
    i_cv[t] = 1'($urandom_range(1, 0));
    i_cd[t] = DW'($urandom);
    i_sv[t] = 1'($urandom_range(1, 0));
    i_sd[t] = DW'($urandom);
    i_sl[t] = 1'($urandom_range(1, 0));
  endfunction

  // vmode: 0 = sample valid every cycle, 1 = alternating 1,0,1.., 2 = random
  function automatic void plan_frame(input int gmin, input int gmax, input int vmode,
                                     output int t_first, output int t_lcf, output int t_end);
    logic [DW-1:0] h [L];
    int t, d, j, gap, n;
    bit pend, valid;
    t = t_now;
    t_first = t;
    n = samp_q.size();
    for (int k = 0; k < L; k++) begin
      h[k] = DW'($urandom);
      gap = int'($urandom_range(gmax, gmin));
      for (int g = 0; g < gap; g++) begin
        base(t, 1'b0); junk(t); i_cv[t] = 1'b0; t++;
      end
      base(t, 1'b0); junk(t); i_cv[t] = 1'b1; i_cd[t] = h[k]; t++;
    end
    t_lcf = t;
    base(t, 1'b1); junk(t); e_lcf[t] = 1'b1; t++;
    for (int k = 0; k < L; k++) begin
      base(t, 1'b1); junk(t); e_coeff[t] = h[k]; t++;
    end
    pend = 1'b0; j = 0; d = 0;
    while (j < n) begin
      base(t, 1'b1); junk(t);
      e_sr[t]  = 1'b1;
      e_csf[t] = (d == 0);
      e_ldf[t] = pend;
      case (vmode)
        0:       valid = 1'b1;
        1:       valid = (d % 2 == 0);
        default: valid = ($urandom_range(2, 0) != 0) || (d > 64);
      endcase
      i_sv[t] = valid;
      if (valid) begin
        i_sd[t] = samp_q[j];
        i_sl[t] = (j == n - 1);
        m_data  = samp_q[j];
        m_cnt   = CW'((j + 1 > CMAX) ? CMAX : j + 1);
        j++;
      end
      pend = valid;
      d++; t++;
    end
    for (int s = 1; s <= 3; s++) begin
      base(t, 1'b1); junk(t);
      if (s == 1) begin e_ldf[t] = 1'b1; e_stop[t] = 1'b1; end
      if (s == 3) e_fd[t] = 1'b1;
      t++;
    end
    t_end = t - 1;
    t_now = t;
  endfunction

  task automatic check_cycle(input int t);
    chk("coef_in_ready", 32'(coef_in_ready), 32'(e_cr[t]));
    chk("samp_in_ready", 32'(samp_in_ready), 32'(e_sr[t]));
    chk("load_coeff_flag", 32'(load_coeff_flag), 32'(e_lcf[t]));
    chk("coeff_set_flag", 32'(coeff_set_flag), 32'(e_csf[t]));
    chk("coeff_in", 32'(coeff_in), 32'(e_coeff[t]));
    chk("load_data_flag", 32'(load_data_flag), 32'(e_ldf[t]));
    chk("stop_flag", 32'(stop_data_load_flag), 32'(e_stop[t]));
    chk("data_in", 32'(data_in), 32'(e_data[t]));
    chk("busy", 32'(busy), 32'(e_busy[t]));
    chk("frame_done", 32'(frame_done), 32'(e_fd[t]));
    chk("sample_count", 32'(sample_count), 32'(e_cnt[t]));
  endtask

  task automatic check_reset();
    chk("rst_coef_in_ready", 32'(coef_in_ready), 32'd1);
    chk("rst_samp_in_ready", 32'(samp_in_ready), 32'd0);
    chk("rst_load_coeff_flag", 32'(load_coeff_flag), 32'd0);
    chk("rst_coeff_set_flag", 32'(coeff_set_flag), 32'd0);
    chk("rst_coeff_in", 32'(coeff_in), 32'd0);
    chk("rst_load_data_flag", 32'(load_data_flag), 32'd0);
    chk("rst_stop_flag", 32'(stop_data_load_flag), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_sample_count", 32'(sample_count), 32'd0);
  endtask

  task automatic finish_reset();
    @(posedge clock); #1;
    coef_in_valid = 1'b0;
    samp_in_valid = 1'b0;
    @(negedge clock);
    t_cur = -1;
    check_reset();
    m_data = '0;
    m_cnt  = '0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0;
    finish_reset();
  endtask

  task automatic run_frame(input int t_first, input int t_end, input int abort);
    for (int t = t_first; t <= t_end; t++) begin
      @(posedge clock); #1;
      reset_n       = (t == abort) ? 1'b0 : 1'b1;
      coef_in_valid = i_cv[t];
      coef_in_data  = i_cd[t];
      samp_in_valid = i_sv[t];
      samp_in_data  = i_sd[t];
      samp_in_last  = i_sl[t];
      @(negedge clock);
      t_cur = t;
      check_cycle(t);
      if (t == abort) begin
        finish_reset();
        break;
      end
    end
  endtask

  task automatic rand_samples(input int n);
    samp_q.delete();
    for (int i = 0; i < n; i++) samp_q.push_back(DW'($urandom));
  endtask

  int tf, tl, te, s1;

  initial begin
    m_data = '0;
    m_cnt  = '0;
    do_reset();

    samp_q = '{18'd10, 18'd20, 18'd30};
    plan_frame(0, 0, 0, tf, tl, te);
    run_frame(tf, te, -1);
    chk("count_after_3", 32'(sample_count), 32'd3);

    rand_samples(3);
    plan_frame(0, 0, 1, tf, tl, te);
    run_frame(tf, te, -1);

    rand_samples(2);
    plan_frame(2, 2, 2, tf, tl, te);
    run_frame(tf, te, -1);

    rand_samples(3);
    plan_frame(0, 1, 0, tf, tl, te);
    run_frame(tf, te, tl + 3);

    rand_samples(4);
    plan_frame(0, 1, 2, tf, tl, te);
    run_frame(tf, te, -1);

    rand_samples(5);
    plan_frame(0, 0, 2, tf, tl, te);
    run_frame(tf, te, -1);
    s1 = stop_t;
    rand_samples(1);
    plan_frame(0, 0, 0, tf, tl, te);
    run_frame(tf, te, -1);
    chk("stop_to_load_gap", 32'((lcf_t - s1) >= 4), 32'd1);
    chk("count_after_1", 32'(sample_count), 32'd1);

    rand_samples(20);
    plan_frame(0, 0, 0, tf, tl, te);
    run_frame(tf, te, -1);
    chk("count_saturated", 32'(sample_count), 32'(CMAX));

    for (int f = 0; f < 5; f++) begin
      rand_samples(int'($urandom_range(6, 1)));
      plan_frame(0, 2, 2, tf, tl, te);
      run_frame(tf, te, -1);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
